uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

UART transmit controller: accepts a parallel word on a valid strobe and sequences one serial frame (start, data LSB-first, optional parity, stop) onto TX_OUT. It owns the TX FSM, the serializer and the output mux. It drives the load strobe of the external UART_TX_Parity_Calc and consumes that block's parity_data during the parity bit. It sits between the register-file/FIFO side and the TX line, clocked by the UART TX clock (one cycle per bit).

## Interface
- DATA_WIDTH, 8, data bits per frame (≥ 2)

- CLK  input  1  TX bit clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- P_DATA  input  DATA_WIDTH  parallel word; sampled only in the accept cycle
- Data_Valid  input  1  request to send P_DATA
- PAR_EN  input  1  parity bit enabled; sampled in the accept cycle
- parity_data  input  1  parity bit from UART_TX_Parity_Calc
- Parity_EN  output  1  one-cycle load strobe to UART_TX_Parity_Calc
- TX_OUT  output  1  serial line, idle high
- Busy  output  1  high while a frame is in progress

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept cycle: Data_Valid=1 while in IDLE or STOP.
  - Captures P_DATA into a shift register and PAR_EN into par_en_q.
  - Asserts Parity_EN combinationally in that cycle only.
  - Next state is START.
- IDLE: TX_OUT=1, Busy=0. Stays in IDLE without Data_Valid.
- START: TX_OUT=0, Busy=1. Lasts one cycle, then DATA with bit counter cleared to 0.
- DATA: TX_OUT = shift_reg[0], shifting right each cycle; counter increments.
  - Lasts exactly DATA_WIDTH cycles.
  - On counter = DATA_WIDTH-1: go to PARITY if par_en_q=1, else STOP.
- PARITY: TX_OUT=parity_data, Busy=1. Lasts one cycle, then STOP.
- STOP: TX_OUT=1, Busy=1. Lasts one cycle.
  - Goes to START if Data_Valid=1 (back-to-back frame, accept performed), else IDLE.
- Data_Valid in START, DATA or PARITY is ignored. The word is not queued, and the upstream must hold it until it is accepted.
- PAR_EN changes mid-frame have no effect on the current frame.
- Bit counter width is $clog2(DATA_WIDTH). It never wraps within a frame.

## Timing
- TX_OUT and Busy are decoded from registered state and the shift register. They are glitch-free and never combinationally dependent on Data_Valid.
- Parity_EN is the only combinational output (Data_Valid & (IDLE|STOP)).
- Latency: accept at edge n; START is visible from cycle n+1; first data bit from n+2.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- Back-to-back frames have exactly one stop bit between them, with no idle gap.
- The parity calculator latches P_DATA at the accept edge. parity_data must be stable from the START state onward; the controller relies on this, with no extra wait.
- Reset (RST=1 at any rising edge, including mid-frame):
  - state=IDLE, counter=0, shift register=0, par_en_q=0.
  - TX_OUT=1 and Busy=0 from the next cycle; Parity_EN=0.
  - An aborted frame is not resumed.
- Data_Valid and RST high together: reset wins, and nothing is accepted.

## Structure
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - mux select constants (SEL_START, SEL_DATA, SEL_PARITY, SEL_STOP)
  - default DATA_WIDTH constant
- Sub-module uart_tx_serializer: shift register plus bit counter, with load/shift enables and a ser_done flag (counter = DATA_WIDTH-1).
- The FSM and the 4:1 output mux stay in uart_tx_ctrl.
- UART_TX_Parity_Calc is instantiated beside this block at top level, not inside it.

## Test plan
- Reset: hold RST=1 for 3 cycles with Data_Valid=1 -> TX_OUT=1, Busy=0, Parity_EN=0 throughout, no frame starts.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 (parity calc in bench) -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1. Busy high for 11 cycles; Parity_EN high exactly in the accept cycle.
- No parity: P_DATA=0x3C, PAR_EN=0 -> 0,0,0,1,1,1,1,0,0,1 over 10 cycles, then idle high with Busy=0.
- Back-to-back with odd parity: 0xFF then 0x01, PAR_TYP=1, Data_Valid held through the first STOP -> second START immediately follows the single stop bit. Parity bits are 1 and 0; total 22 Busy cycles.
- Busy-time request: pulse Data_Valid with P_DATA=0x55 during DATA of a 0x00 frame -> frame 0x00 is unaffected and 0x55 is never sent.
- Mid-frame reset: assert RST for one cycle during data bit 4 -> TX_OUT=1 and Busy=0 next cycle. A new Data_Valid afterwards produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART TX controller
// Purpose: FSM state enum, output-mux selects and default frame width.
// Ports: none (package).
package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  typedef logic [1:0] tx_sel_t;

  localparam tx_sel_t SEL_START  = 2'd0;
  localparam tx_sel_t SEL_DATA   = 2'd1;
  localparam tx_sel_t SEL_PARITY = 2'd2;
  localparam tx_sel_t SEL_STOP   = 2'd3;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - word-in / serial-out bundle of the UART TX controller
// Purpose: groups the upstream request, parity-calculator link and line outputs.
// Ports: P_DATA, Data_Valid, PAR_EN, parity_data (towards controller);
//        Parity_EN, TX_OUT, Busy (from controller).
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  parity_data;
  logic                  Parity_EN;
  logic                  TX_OUT;
  logic                  Busy;

  // Environment side: upstream word source plus the parity calculator.
  modport master (
    output P_DATA, Data_Valid, PAR_EN, parity_data,
    input  Parity_EN, TX_OUT, Busy
  );

  // Controller side.
  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, parity_data,
    output Parity_EN, TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - shift register and bit counter for one frame
// Purpose: holds the data word, presents the current LSB, counts data bits.
// Ports: clk_i, rst_i (sync active-high), load_i (capture data_i, clear count),
//        shift_i (advance one bit), data_i, bit_o (current bit),
//        ser_done_o (last data bit is on the line).
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bit_o,
  output logic                  ser_done_o
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      cnt_q;

  assign bit_o      = shift_q[0];
  assign ser_done_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
      cnt_q   <= '0;
    end else if (shift_i) begin
      shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
      // Hold at the last index so a power-of-two width cannot wrap.
      if (!ser_done_o) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit FSM, serializer and output mux
// Purpose: accepts a word from IDLE or STOP and sends start, data LSB-first,
//          optional parity and stop bit, one bit per CLK.
// Ports: CLK, RST (sync active-high), bus (uart_tx_ctrl_if.slave).
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic         CLK,
  input  logic         RST,
  uart_tx_ctrl_if.slave bus
);
  state_e  state_q, state_d;
  logic    par_en_q;
  logic    accept;
  logic    ser_bit;
  logic    ser_done;
  tx_sel_t sel;

  // Reset wins over a simultaneous request, so the parity strobe is gated too.
  assign accept = bus.Data_Valid && !RST && (state_q == IDLE || state_q == STOP);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (accept),
    .shift_i    (state_q == DATA),
    .data_i     (bus.P_DATA),
    .bit_o      (ser_bit),
    .ser_done_o (ser_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        par_en_q <= bus.PAR_EN;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel     = SEL_STOP;
    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        sel     = SEL_START;
        state_d = DATA;
      end
      DATA: begin
        sel = SEL_DATA;
        if (ser_done) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        sel     = SEL_PARITY;
        state_d = STOP;
      end
      STOP: begin
        state_d = accept ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.TX_OUT = 1'b1;
    case (sel)
      SEL_START:  bus.TX_OUT = 1'b0;
      SEL_DATA:   bus.TX_OUT = ser_bit;
      SEL_PARITY: bus.TX_OUT = bus.parity_data;
      default:    bus.TX_OUT = 1'b1;
    endcase
  end

  assign bus.Busy      = (state_q != IDLE);
  assign bus.Parity_EN = accept;
endmodule
